id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand forwarding and load-use hazard detection.
- Sits directly upstream of the 32-bit ALU and drives its ALUcontrol, dataA and dataB inputs.
- Registers decoded instruction fields from ID and selects forwarded EX/MEM or MEM/WB results for the operands.
- Issues a one-bubble stall on a load-use hazard and accepts a flush for branch redirect.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register-index width
- CTRL_W, 4, ALU control width (encodings 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW  register indices
- id_alu_ctrl  in  CTRL_W  ALU operation
- id_alu_src  in  1  1 = dataB from immediate
- id_reg_dst  in  1  1 = destination is rd, else rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- flush  in  1  squash the instruction entering EX
- exm_reg_write  in  1  EX/MEM writes a register
- exm_rd  in  REG_AW  EX/MEM destination
- exm_result  in  DATA_W  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB writes a register
- wb_rd  in  REG_AW  MEM/WB destination
- wb_result  in  DATA_W  MEM/WB write-back data
- hazard_stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a valid instruction
- alu_ctrl  out  CTRL_W  to ALU ALUcontrol
- alu_a, alu_b  out  DATA_W  to ALU dataA/dataB
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_dest  out  REG_AW  resolved destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  control bits gated by ex_valid

Behaviour:
- Reset (async, rst_n=0): all registers cleared. ex_valid=0, alu_ctrl=0000, ex_dest=0, all gated controls 0.
- Reset mid-operation discards the in-flight instruction with no partial state retained.
- Load-use hazard: hazard_stall = ex_valid & ex_mem_read & id_valid & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
- Register update priority: flush > hazard_stall > normal.
  - flush or hazard_stall: ex_valid<=0 (bubble); other fields don't-care but held.
  - Normal: capture all id_* fields; ex_valid<=id_valid.
- Latency: one cycle from ID fields to EX outputs. A stalled instruction enters EX on the cycle after the stall, so exactly one bubble is inserted.
- ex_dest = reg_dst ? rd : rt, resolved at capture.
- Gated controls = stored bit & ex_valid.
- Forwarding, per source operand (rs→A, rt→B/store), combinational from stored index:
  - EX/MEM match (exm_reg_write & exm_rd!=0 & exm_rd==idx) selects exm_result.
  - Else MEM/WB match (same rule) selects wb_result.
  - Else the captured register data.
  - EX/MEM has priority when both match. Index 0 is never forwarded.
- alu_b = alu_src ? imm : forwarded rt. ex_store_data is always forwarded rt.
- Simultaneous flush and hazard: flush wins. hazard_stall remains asserted combinationally; the upstream fetch stage gives flush precedence.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - Operands come only from captured register data.
  - hazard_stall additionally asserts on any RAW between id_rs/id_rt and a valid writing instruction in EX, EX/MEM, or MEM/WB (rd!=0).
  - For the EX and EX/MEM comparisons, the stage uses internally registered copies of its own previous ex_dest/ex_reg_write.
  - Stall repeats until the hazard clears.

Decomposition:
- Shared package (cpu_pkg): ALU control encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR), DATA_W/REG_AW defaults, and a packed struct for the ID/EX control bundle.
- One sub-module, fwd_mux: a single operand's forwarding comparator plus 3:1 mux, instantiated twice.

Test Plan:
- Reset: rst_n low mid-stream → ex_valid=0, alu_ctrl=0000, all gated controls 0 within the same cycle.
- EX/MEM forward: add $3 in EX/MEM with exm_result=0x00000010, ID uses rs=$3, id_rs_data=0x0 → alu_a=0x00000010 one cycle after capture.
- Double hazard: EX/MEM $3=0x10 and MEM/WB $3=0x20 both match → alu_a=0x10; with rs=$0 and exm_rd=0, alu_a=id_rs_data.
- Load-use: lw $5 in EX, ID add rs=$5 → hazard_stall=1 for one cycle, next ex_valid=0, following cycle add enters with alu_a=wb/exm forwarded load value.
- Flush with id_valid=1 and id_reg_write=1 → next ex_valid=0, ex_reg_write=0; flush plus hazard → bubble, no duplicate issue.
- Immediate path: alu_src=1, id_imm=0xFFFFFFFC, rt forwarded 0x55 → alu_b=0xFFFFFFFC, ex_store_data=0x55.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU encodings, width defaults
// and the ID/EX control bundle.
package cpu_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int REG_AW_DFLT = 5;
  localparam int CTRL_W_DFLT = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef struct packed {
    logic alu_src;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } id_ex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// One operand's forwarding compare and 3:1 select.
// EX/MEM beats MEM/WB; register index 0 never forwards.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_AW = REG_AW_DFLT
) (
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exm_we_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic exm_hit;
  logic wb_hit;
  logic sel_exm;
  logic sel_wb;

  assign exm_hit = exm_we_i
                 & (exm_rd_i != '0)
                 & (exm_rd_i == idx_i);
  assign wb_hit  = wb_we_i
                 & (wb_rd_i != '0)
                 & (wb_rd_i == idx_i);

  // One-hot selects keep the decoder unique.
  assign sel_exm = exm_hit;
  assign sel_wb  = wb_hit & ~exm_hit;

  always_comb begin
    data_o = reg_data_i;
    unique case (1'b1)
      sel_exm: data_o = exm_data_i;
      sel_wb:  data_o = wb_data_i;
      default: data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding and hazard stall.
// EX_FORWARD_EN: forward from EX/MEM, MEM/WB; else stall on RAW.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_AW = REG_AW_DFLT,
  parameter int CTRL_W = CTRL_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  id_ex_ctrl_t       ctrl_d;
  id_ex_ctrl_t       ctrl_q;
  logic              ex_valid_d;
  logic              ex_valid_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] dest_d;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              load_use;
  logic              capture;
  logic              fwd_exm_we;
  logic              fwd_wb_we;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.alu_src    = id_alu_src;
    ctrl_d.reg_write  = id_reg_write;
    ctrl_d.mem_read   = id_mem_read;
    ctrl_d.mem_write  = id_mem_write;
    ctrl_d.mem_to_reg = id_mem_to_reg;
  end

  assign dest_d = id_reg_dst ? id_rd : id_rt;

  assign load_use = ex_valid_q
                  & ctrl_q.mem_read
                  & id_valid
                  & (rt_q != '0)
                  & ((rt_q == id_rs) | (rt_q == id_rt));

  // Flush and stall both turn the incoming slot into a bubble.
  assign capture    = ~(flush | hazard_stall);
  assign ex_valid_d = capture & id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      alu_ctrl_q <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (capture) begin
        ctrl_q     <= ctrl_d;
        alu_ctrl_q <= id_alu_ctrl;
        rs_q       <= id_rs;
        rt_q       <= id_rt;
        dest_q     <= dest_d;
        rs_data_q  <= id_rs_data;
        rt_data_q  <= id_rt_data;
        imm_q      <= id_imm;
      end
    end
  end

`ifdef EX_FORWARD_EN
  assign hazard_stall = load_use;
  assign fwd_exm_we   = exm_reg_write;
  assign fwd_wb_we    = wb_reg_write;
`else
  logic              exm_we_q;
  logic [REG_AW-1:0] exm_dest_q;
  logic              raw;
  logic              unused_exm_we;

  function automatic logic raw_on(
    input logic              we,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] a,
    input logic [REG_AW-1:0] b
  );
    return we && (rd != '0) && ((rd == a) || (rd == b));
  endfunction

  // Shadow of the instruction that just left EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_we_q   <= 1'b0;
      exm_dest_q <= '0;
    end else begin
      exm_we_q   <= ex_reg_write;
      exm_dest_q <= dest_q;
    end
  end

  assign raw = id_valid & (
      raw_on(ex_reg_write, dest_q, id_rs, id_rt)
    | raw_on(exm_we_q, exm_dest_q, id_rs, id_rt)
    | raw_on(wb_reg_write, wb_rd, id_rs, id_rt));

  assign hazard_stall  = load_use | raw;
  assign fwd_exm_we    = 1'b0;
  assign fwd_wb_we     = 1'b0;
  assign unused_exm_we = exm_reg_write;
`endif

  fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .idx_i      (rs_q),
    .reg_data_i (rs_data_q),
    .exm_we_i   (fwd_exm_we),
    .exm_rd_i   (exm_rd),
    .exm_data_i (exm_result),
    .wb_we_i    (fwd_wb_we),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_result),
    .data_o     (fwd_a)
  );

  fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .idx_i      (rt_q),
    .reg_data_i (rt_data_q),
    .exm_we_i   (fwd_exm_we),
    .exm_rd_i   (exm_rd),
    .exm_data_i (exm_result),
    .wb_we_i    (fwd_wb_we),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_result),
    .data_o     (fwd_b)
  );

  assign ex_valid      = ex_valid_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign alu_a         = fwd_a;
  assign alu_b         = ctrl_q.alu_src ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = ctrl_q.reg_write  & ex_valid_q;
  assign ex_mem_read   = ctrl_q.mem_read   & ex_valid_q;
  assign ex_mem_write  = ctrl_q.mem_write  & ex_valid_q;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg & ex_valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage.
// Expectations adapt to EX_FORWARD_EN.
module tb_id_ex_operand_stage;
  import cpu_pkg::*;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        hazard_stall;
  logic        ex_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [3:0]  ctl_o;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic [3:0]  ctl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tot  = 0;
  int   n_pass = 0;

  id_ex_operand_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_alu_ctrl   (id_alu_ctrl),
    .id_alu_src    (id_alu_src),
    .id_reg_dst    (id_reg_dst),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_mem_to_reg (id_mem_to_reg),
    .flush         (flush),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .hazard_stall  (hazard_stall),
    .ex_valid      (ex_valid),
    .alu_ctrl      (alu_ctrl),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .ex_store_data (ex_store_data),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg)
  );

  assign ctl_o = {ex_reg_write, ex_mem_read,
                  ex_mem_write, ex_mem_to_reg};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // cb = {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg}
  task automatic id_ins(input logic [4:0]  rs, rt, rd,
                        input logic [31:0] rsd, rtd, imm,
                        input logic [3:0]  op,
                        input logic [5:0]  cb);
    id_valid      = 1'b1;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rd;
    id_rs_data    = rsd;
    id_rt_data    = rtd;
    id_imm        = imm;
    id_alu_ctrl   = op;
    id_alu_src    = cb[5];
    id_reg_dst    = cb[4];
    id_reg_write  = cb[3];
    id_mem_read   = cb[2];
    id_mem_write  = cb[1];
    id_mem_to_reg = cb[0];
  endtask

  task automatic id_idle();
    id_ins(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
           4'h0, 6'b000000);
    id_valid = 1'b0;
  endtask

  task automatic ctx(input logic xw, input logic [4:0] xr,
                     input logic [31:0] xd,
                     input logic ww, input logic [4:0] wr,
                     input logic [31:0] wd);
    exm_reg_write = xw;
    exm_rd        = xr;
    exm_result    = xd;
    wb_reg_write  = ww;
    wb_rd         = wr;
    wb_result     = wd;
  endtask

  task automatic push(input logic [31:0] a, b, st,
                      input logic [3:0] op,
                      input logic [4:0] dest,
                      input logic [3:0] ctl);
    exp_t x;
    x.a    = a;
    x.b    = b;
    x.st   = st;
    x.op   = op;
    x.dest = dest;
    x.ctl  = ctl;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n && ex_valid) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL sb_unexpected: ex_valid=1 dest=%0d, none expected",
                 ex_dest);
      end else begin
        e = sb.pop_front();
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("store_data", ex_store_data, e.st);
        chk("alu_ctrl", {28'h0, alu_ctrl}, {28'h0, e.op});
        chk("ex_dest", {27'h0, ex_dest}, {27'h0, e.dest});
        chk("ex_ctl", {28'h0, ctl_o}, {28'h0, e.ctl});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    id_idle();
    ctx(0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_dest", ex_dest, 0);
    chk("rst_ctl", ctl_o, 0);
    tick();
    rst_n = 1'b1;

    // add $6,$3,$4 then $3 forwarded from EX/MEM over MEM/WB
    id_ins(3, 4, 6, 32'h0, 32'h7, 32'h0, ALU_ADD, 6'b011000);
    push(FWD ? 32'h10 : 32'h0, 32'h7, 32'h7, ALU_ADD, 6, 4'b1000);
    settle();
    chk("stall_i1", hazard_stall, 0);
    tick();
    ctx(1, 3, 32'h10, 1, 3, 32'h20);
    id_ins(0, 0, 9, 32'h123, 32'h456, 32'h0, ALU_OR, 6'b001000);
    push(32'h123, 32'h456, 32'h456, ALU_OR, 0, 4'b1000);
    settle();
    chk("stall_i2", hazard_stall, 0);
    tick();
    ctx(1, 0, 32'hdead, 1, 0, 32'hbeef);
    id_idle();

    // lw $5, 8($1) followed by dependent add
    tick();
    ctx(0, 0, 0, 0, 0, 0);
    id_ins(1, 5, 0, 32'h100, 32'h77, 32'h8, ALU_ADD, 6'b101101);
    push(32'h100, 32'h8, 32'h77, ALU_ADD, 5, 4'b1101);
    settle();
    chk("stall_lw", hazard_stall, 0);
    tick();
    id_ins(5, 2, 7, 32'h0, 32'h3, 32'h0, ALU_ADD, 6'b011000);
    push(32'hcafe, 32'h3, 32'h3, ALU_ADD, 7, 4'b1000);
    settle();
    chk("stall_load_use", hazard_stall, 1);
    tick();
    ctx(1, 5, 32'h108, 0, 0, 0);
    settle();
    chk("stall_after_bubble", hazard_stall, FWD ? 0 : 1);
    chk("bubble_valid", ex_valid, 0);
    tick();
    ctx(0, 0, 0, 1, 5, 32'hcafe);
`ifdef EX_FORWARD_EN
    id_idle();
    settle();
    chk("stall_c7", hazard_stall, 0);
`else
    id_rs_data = 32'hcafe;
    settle();
    chk("stall_wb_raw", hazard_stall, 1);
    chk("bubble2_valid", ex_valid, 0);
    tick();
    ctx(0, 0, 0, 0, 0, 0);
    settle();
    chk("stall_clear", hazard_stall, 0);
`endif
    tick();
    ctx(0, 0, 0, 0, 0, 0);
    id_idle();

    // flush squashes a writing instruction
    tick();
    id_ins(11, 12, 13, 32'h1, 32'h2, 32'h0, ALU_SUB, 6'b011000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_idle();
    settle();
    chk("flush_valid", ex_valid, 0);
    chk("flush_reg_write", ex_reg_write, 0);

    // flush together with load-use: bubble only
    id_ins(0, 8, 0, 32'h200, 32'h0, 32'h4, ALU_ADD, 6'b101101);
    push(32'h200, 32'h4, 32'h0, ALU_ADD, 8, 4'b1101);
    settle();
    chk("stall_lw2", hazard_stall, 0);
    tick();
    id_ins(8, 1, 3, 32'h0, 32'h0, 32'h0, ALU_ADD, 6'b011000);
    flush = 1'b1;
    settle();
    chk("stall_with_flush", hazard_stall, 1);
    tick();
    flush = 1'b0;
    id_idle();
    settle();
    chk("flush_hz_valid", ex_valid, 0);
    tick();

    // reset in the middle of a live instruction
    tick();
    id_ins(2, 10, 0, 32'h0, 32'h0, 32'h0, ALU_SUB, 6'b001100);
    tick();
    id_idle();
    rst_n = 1'b0;
    settle();
    chk("mrst_valid", ex_valid, 0);
    chk("mrst_alu_ctrl", alu_ctrl, 0);
    chk("mrst_dest", ex_dest, 0);
    chk("mrst_ctl", ctl_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    chk("post_rst_valid", ex_valid, 0);

    // store with immediate operand and forwarded rt
    id_ins(0, 9, 0, 32'h40, 32'h0, 32'hFFFFFFFC, ALU_ADD, 6'b100010);
    push(32'h40, 32'hFFFFFFFC, FWD ? 32'h55 : 32'h0,
         ALU_ADD, 9, 4'b0010);
    settle();
    chk("stall_sw", hazard_stall, 0);
    tick();
    id_idle();
    ctx(1, 9, 32'h55, 0, 0, 0);
    tick();
    ctx(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
